// File: rtl/apb_pkg.sv
// Shared types, widths and address-decode helper for the APB register bank.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic {IDLE, ACCESS} apb_slv_state_t;

  // True when addr falls in [base, base + n*4). The sum is formed one bit
  // wider so a bank placed at the top of the map cannot wrap to zero.
  function automatic logic addr_in_range(input logic [APB_ADDR_W-1:0] addr,
                                         input logic [APB_ADDR_W-1:0] base,
                                         input int unsigned          n);
    logic [APB_ADDR_W:0] lim;
    lim = {1'b0, base} + {1'b0, n * 32'd4};
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle between the SoC master and the register-bank slave.
//   psel/penable/pwrite/paddr/pwdata : master -> slave
//   prdata/pready/pslverr            : slave  -> master
interface apb_slave_regbank_if;
  import apb_pkg::*;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_reg_bank.sv
// Register storage for the APB slave.
//   clk, rst             : clock, synchronous active-high reset
//   wr_en/wr_idx/wr_data : single write port, commits on the clock edge
//   rd_idx/rd_data       : combinational read port
//   regs                 : flat contents, register k at [32k+31:32k]
//   wr_strobe            : one-cycle pulse per register after its write
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int                    NUM_REGS  = 8,
  parameter logic [APB_DATA_W-1:0] RESET_VAL = '0,
  localparam int                   IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [APB_DATA_W-1:0]          wr_data,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [APB_DATA_W-1:0]          rd_data,
  output logic [NUM_REGS*APB_DATA_W-1:0] regs,
  output logic [NUM_REGS-1:0]            wr_strobe
);

  logic [NUM_REGS-1:0][APB_DATA_W-1:0] regs_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic [APB_DATA_W-1:0] q;
    logic                  stb;
    logic                  hit;

    assign hit = wr_en && (wr_idx == IDX_W'(g));

    always_ff @(posedge clk) begin
      if (rst) begin
        q   <= RESET_VAL;
        stb <= 1'b0;
      end else begin
        stb <= hit;
        if (hit) q <= wr_data;
      end
    end

    assign regs_q[g]    = q;
    assign wr_strobe[g] = stb;
  end

  assign rd_data = regs_q[rd_idx];
  assign regs    = regs_q;

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave with NUM_REGS 32-bit R/W registers, fixed wait states and
// slave-error on out-of-range or misaligned addresses.
//   i_clk_apb, i_rst_apb : clock, synchronous active-high reset
//   bus                  : APB slave port (psel..pwdata in, prdata/pready/pslverr out)
//   o_regs               : flat register contents for the peripheral
//   o_wr_strobe          : per-register pulse in the cycle after a write commits
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [APB_DATA_W-1:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic                           i_clk_apb,
  input  logic                           i_rst_apb,
  apb_slave_regbank_if.slave             bus,
  output logic [NUM_REGS*APB_DATA_W-1:0] o_regs,
  output logic [NUM_REGS-1:0]            o_wr_strobe
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_N = CNT_W'(WAIT_CYCLES);

  apb_slv_state_t        state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      h_idx;
  logic                  h_wr;
  logic [APB_DATA_W-1:0] h_wdata;
  logic                  h_err;

  logic                  pready;
  logic                  wr_en;
  logic [APB_DATA_W-1:0] rd_data;

  // Completion depends only on registered state/counter plus the live
  // psel/penable; reset masks it so a transfer caught by reset never
  // responds or commits.
  assign pready = !i_rst_apb && (state == ACCESS) && bus.psel && bus.penable &&
                  (cnt == WAIT_N);
  assign wr_en  = pready && h_wr && !h_err;

  always_ff @(posedge i_clk_apb) begin
    if (i_rst_apb) begin
      state   <= IDLE;
      cnt     <= '0;
      h_idx   <= '0;
      h_wr    <= 1'b0;
      h_wdata <= '0;
      h_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Only a proper setup phase starts a transfer; a stray penable
          // without one is ignored.
          if (bus.psel && !bus.penable) begin
            h_idx   <= bus.paddr[IDX_W+1:2];
            h_wr    <= bus.pwrite;
            h_wdata <= bus.pwdata;
            h_err   <= !addr_in_range(bus.paddr, BASE_ADDR, NUM_REGS) ||
                       (bus.paddr[1:0] != 2'b00);
            cnt     <= '0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!bus.psel) begin
            state <= IDLE;          // master abandoned the transfer
          end else if (pready) begin
            state <= IDLE;          // next setup may follow immediately
          end else if (bus.penable && (cnt < WAIT_N)) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .clk       (i_clk_apb),
    .rst       (i_rst_apb),
    .wr_en     (wr_en),
    .wr_idx    (h_idx),
    .wr_data   (h_wdata),
    .rd_idx    (h_idx),
    .rd_data   (rd_data),
    .regs      (o_regs),
    .wr_strobe (o_wr_strobe)
  );

  assign bus.pready  = pready;
  assign bus.pslverr = pready && h_err;
  assign bus.prdata  = (pready && !h_wr && !h_err) ? rd_data : '0;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench: two slaves (WAIT_CYCLES=1 and 0) on shared APB data lines with
// separate selects, checked against a per-slave register-array model.
module tb_apb_slave_regbank;

  localparam logic [31:0] RST0 = 32'h0000_0000;
  localparam logic [31:0] RST1 = 32'hC0DE_0001;
  localparam int WAITS [2] = '{1, 0};

  logic        clk = 1'b0;
  logic        rst;
  logic        psel0, psel1, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [255:0] regs0, regs1;
  logic [7:0]   stb0, stb1;

  apb_slave_regbank_if bus0 ();
  apb_slave_regbank_if bus1 ();

  assign bus0.psel = psel0;   assign bus1.psel = psel1;
  assign bus0.penable = penable; assign bus1.penable = penable;
  assign bus0.pwrite = pwrite;   assign bus1.pwrite = pwrite;
  assign bus0.paddr = paddr;     assign bus1.paddr = paddr;
  assign bus0.pwdata = pwdata;   assign bus1.pwdata = pwdata;

  apb_slave_regbank #(.BASE_ADDR(32'h0), .NUM_REGS(8), .WAIT_CYCLES(1), .RESET_VAL(RST0)) dut0 (
    .i_clk_apb(clk), .i_rst_apb(rst), .bus(bus0), .o_regs(regs0), .o_wr_strobe(stb0));
  apb_slave_regbank #(.BASE_ADDR(32'h0), .NUM_REGS(8), .WAIT_CYCLES(0), .RESET_VAL(RST1)) dut1 (
    .i_clk_apb(clk), .i_rst_apb(rst), .bus(bus1), .o_regs(regs1), .o_wr_strobe(stb1));

  always #5 clk = ~clk;

  logic        rdy [2];
  logic        serr[2];
  logic [31:0] prd [2];
  logic [255:0] regs[2];
  logic [7:0]  stb [2];
  assign rdy[0] = bus0.pready;  assign rdy[1] = bus1.pready;
  assign serr[0] = bus0.pslverr; assign serr[1] = bus1.pslverr;
  assign prd[0] = bus0.prdata;  assign prd[1] = bus1.prdata;
  assign regs[0] = regs0;       assign regs[1] = regs1;
  assign stb[0] = stb0;         assign stb[1] = stb1;

  // Reference: plain register arrays, one per slave.
  logic [31:0] mdl [2][8];
  int vecs = 0;
  int errs = 0;

  function automatic logic [255:0] flat(input int d);
    logic [255:0] f;
    for (int k = 0; k < 8; k++) f[k*32 +: 32] = mdl[d][k];
    return f;
  endfunction

  task automatic mdl_reset();
    for (int k = 0; k < 8; k++) begin
      mdl[0][k] = RST0;
      mdl[1][k] = RST1;
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sel(input int d, input logic v);
    if (d == 0) psel0 = v; else psel1 = v;
  endtask

  // One complete APB transfer; entered and left just after a rising edge so
  // successive calls are back-to-back with no idle cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input bit scramble);
    bit bad;
    int idx;
    int c;
    logic [7:0] exp_stb;
    bad = (a >= 32) || (a % 4 != 0);
    idx = int'(a[4:2]);
    set_sel(d, 1'b1); penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    for (c = 1; c <= 20; c++) begin
      if (scramble) begin paddr = $urandom; pwdata = $urandom; end
      @(negedge clk);
      chk("strobe_in_access", 256'(stb[d]), 256'(0));
      if (rdy[d] === 1'b1) break;
      chk("outputs_while_waiting", 256'({prd[d], serr[d]}), 256'(0));
      @(posedge clk); #1;
    end
    chk("pready_latency", 256'(c), 256'(1 + WAITS[d]));
    chk("pslverr", 256'(serr[d]), 256'(bad));
    chk("prdata", 256'(prd[d]), (!wr && !bad) ? 256'(mdl[d][idx]) : 256'(0));
    @(posedge clk); #1;
    set_sel(d, 1'b0); penable = 1'b0;
    exp_stb = '0;
    if (wr && !bad) begin
      mdl[d][idx] = wd;
      exp_stb[idx] = 1'b1;
    end
    chk("wr_strobe", 256'(stb[d]), 256'(exp_stb));
    chk("regs", regs[d], flat(d));
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("strobe_idle0", 256'(stb0), 256'(0));
    chk("strobe_idle1", 256'(stb1), 256'(0));
  endtask

  initial begin
    rst = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    mdl_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out0", 256'({prd[0], rdy[0], serr[0], stb0}), 256'(0));
    chk("reset_out1", 256'({prd[1], rdy[1], serr[1], stb1}), 256'(0));
    chk("reset_regs0", regs0, flat(0));
    chk("reset_regs1", regs1, flat(1));
    @(posedge clk); #1; rst = 1'b0;

    // Directed, WAIT_CYCLES=1 slave.
    xfer(0, 1, 32'h04, 32'hDEAD_BEEF, 0);
    chk("plan_reg1", 256'(regs0[63:32]), 256'(32'hDEAD_BEEF));
    idle_cycle();
    xfer(0, 0, 32'h04, 32'h0, 0);
    xfer(0, 0, 32'h08, 32'h0, 0);
    xfer(0, 1, 32'h20, 32'h1111_1111, 0);
    xfer(0, 1, 32'h06, 32'h2222_2222, 0);
    xfer(0, 0, 32'h20, 32'h0, 0);

    // WAIT_CYCLES=0 slave, back-to-back.
    xfer(1, 1, 32'h00, 32'h1, 0);
    xfer(1, 0, 32'h00, 32'h0, 0);
    xfer(1, 1, 32'h1C, 32'h5A, 0);
    chk("plan_reg7", 256'(regs1[255:224]), 256'(32'h5A));

    // Abort: psel drops during the wait cycle of a write to 0x0C.
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hBAD0_BAD0;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk);
    chk("abort_no_ready", 256'(rdy[0]), 256'(0));
    @(posedge clk); #1; psel0 = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 256'({prd[0], rdy[0], serr[0]}), 256'(0));
    idle_cycle();
    chk("abort_regs", regs0, flat(0));
    xfer(0, 0, 32'h0C, 32'h0, 0);

    // Reset asserted in the completion cycle of a write on the zero-wait slave.
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h7777_7777;
    @(posedge clk); #1; penable = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_out", 256'({prd[1], rdy[1], serr[1]}), 256'(0));
    @(posedge clk); #1; rst = 1'b0; psel1 = 1'b0; penable = 1'b0;
    mdl_reset();
    chk("rst_regs0", regs0, flat(0));
    chk("rst_regs1", regs1, flat(1));
    chk("rst_strobes", 256'({stb0, stb1}), 256'(0));
    xfer(1, 0, 32'h10, 32'h0, 0);

    // Stray penable with no setup phase.
    psel1 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hFFFF_0000;
    repeat (2) begin
      @(negedge clk);
      chk("stray_no_ready", 256'(rdy[1]), 256'(0));
      @(posedge clk); #1;
    end
    psel1 = 1'b0; penable = 1'b0;
    idle_cycle();
    chk("stray_regs", regs1, flat(1));

    // Address/data wiggled during ACCESS: held copies must win.
    xfer(0, 1, 32'h18, 32'h0BAD_CAFE, 1);
    xfer(0, 0, 32'h18, 32'h0, 1);
    xfer(1, 1, 32'h14, 32'h1357_9BDF, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(39, 0));
      if ($urandom_range(3, 0) != 0) a[1:0] = 2'b00;
      xfer(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), a, $urandom,
           1'($urandom_range(1, 0)));
      if ($urandom_range(4, 0) == 0) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
